// File: rtl/ysyx_220066_clint_if.sv
// Request/response bus between the LSU (master) and the CLINT register window (slave).
interface ysyx_220066_clint_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_220066_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a request/response port, plus a held
// interrupt request for the CSR unit. Define YSYX_220066_CLINT_SWI_EN to implement msip.
module ysyx_220066_clint #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_220066_clint_if.slave  bus,
    input  logic                intr_en,
    input  logic                intr_ack,
    output logic                intr_req,
    output logic [63:0]         intr_no,
    output logic                mtip,
    output logic                msip_o
);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
    localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
    localparam logic [63:0] CAUSE_SOFT    = 64'h8000_0000_0000_0003;
    localparam logic [63:0] CAUSE_TIMER   = 64'h8000_0000_0000_0007;
    localparam logic [15:0] DIV_LAST      = 16'(TICK_DIV - 1);

    typedef enum logic { BUS_IDLE, BUS_RESP } bus_state_t;
    typedef enum logic [1:0] { INTR_IDLE, INTR_REQ, INTR_HOLD } intr_state_t;

    function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                                 input logic [63:0] wdata,
                                                 input logic [7:0]  wmask);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

    bus_state_t  bus_state, bus_next;
    intr_state_t intr_state, intr_next;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] div_cnt;
    logic        tick;

    logic        accept;
    logic        hit_msip, hit_mtimecmp, hit_mtime, mapped;
    logic        wr_mtime, wr_mtimecmp;
    logic [63:0] rd_sel;
    logic [63:0] rdata_p1;
    logic        err_p1;

    logic        take_intr;
    logic [63:0] cause;

    // Address decode: exact match on the three registers also rejects misaligned offsets.
    assign hit_msip     = (bus.req_addr == ADDR_MSIP);
    assign hit_mtimecmp = (bus.req_addr == ADDR_MTIMECMP);
    assign hit_mtime    = (bus.req_addr == ADDR_MTIME);
    assign mapped       = hit_msip | hit_mtimecmp | hit_mtime;

    assign accept      = (bus_state == BUS_IDLE) && bus.req_valid;
    assign wr_mtime    = accept && bus.req_wen && hit_mtime;
    assign wr_mtimecmp = accept && bus.req_wen && hit_mtimecmp;

    always_ff @(posedge clk) begin
        if (rst) bus_state <= BUS_IDLE;
        else     bus_state <= bus_next;
    end

    always_comb begin
        bus_next       = bus_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (bus_state)
            BUS_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) bus_next = BUS_RESP;
            end
            BUS_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) bus_next = BUS_IDLE;
            end
            default: bus_next = BUS_IDLE;
        endcase
    end

`ifdef YSYX_220066_CLINT_SWI_EN
    logic msip;
    logic wr_msip;

    assign wr_msip = accept && bus.req_wen && hit_msip;

    always_ff @(posedge clk) begin
        if (rst)                            msip <= 1'b0;
        else if (wr_msip && bus.req_wmask[0]) msip <= bus.req_wdata[0];
    end

    assign msip_o = msip;
`else
    assign msip_o = 1'b0;
`endif

    always_comb begin
        rd_sel = '0;
        if (hit_mtimecmp) rd_sel = mtimecmp;
        if (hit_mtime)    rd_sel = mtime;
`ifdef YSYX_220066_CLINT_SWI_EN
        if (hit_msip)     rd_sel = {63'b0, msip};
`endif
    end

    // Response stage: captured on the accept edge and held until the LSU takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            rdata_p1 <= (bus.req_wen || !mapped) ? 64'd0 : rd_sel;
            err_p1   <= ~mapped;
        end
    end

    assign bus.resp_rdata = rdata_p1;
    assign bus.resp_err   = err_p1;

    assign tick = (div_cnt == DIV_LAST);

    // A bus write to mtime wins over a coincident tick and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime   <= '0;
            div_cnt <= '0;
        end else if (wr_mtime) begin
            mtime   <= merge_lanes(mtime, bus.req_wdata, bus.req_wmask);
            div_cnt <= '0;
        end else if (tick) begin
            mtime   <= mtime + 64'd1;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)              mtimecmp <= '1;
        else if (wr_mtimecmp) mtimecmp <= merge_lanes(mtimecmp, bus.req_wdata, bus.req_wmask);
    end

    assign mtip = (mtime >= mtimecmp);

    assign take_intr = intr_en & (msip_o | mtip);
    assign cause     = msip_o ? CAUSE_SOFT : CAUSE_TIMER;

    always_ff @(posedge clk) begin
        if (rst) intr_state <= INTR_IDLE;
        else     intr_state <= intr_next;
    end

    // HOLD keeps the request low for one cycle so the trap's MIE update lands before re-sampling.
    always_comb begin
        intr_next = intr_state;
        case (intr_state)
            INTR_IDLE: if (take_intr) intr_next = INTR_REQ;
            INTR_REQ:  if (intr_ack)  intr_next = INTR_HOLD;
            INTR_HOLD: intr_next = INTR_IDLE;
            default:   intr_next = INTR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                           intr_no <= '0;
        else if ((intr_state == INTR_IDLE) && take_intr) intr_no <= cause;
    end

    assign intr_req = (intr_state == INTR_REQ);

endmodule

// File: tb/tb_ysyx_220066_clint.sv
// Randomized scoreboard bench for the CLINT against a time-based reference model.
`timescale 1ns/1ps
module tb_ysyx_220066_clint;

    localparam int unsigned TD      = 4;
    localparam logic [63:0] C_SOFT  = 64'h8000_0000_0000_0003;
    localparam logic [63:0] C_TIMER = 64'h8000_0000_0000_0007;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        intr_en;
    logic        intr_ack;
    logic        intr_req;
    logic [63:0] intr_no;
    logic        mtip;
    logic        msip_o;

    ysyx_220066_clint_if bus();

    ysyx_220066_clint #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .intr_en  (intr_en),
        .intr_ack (intr_ack),
        .intr_req (intr_req),
        .intr_no  (intr_no),
        .mtip     (mtip),
        .msip_o   (msip_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: mtime is base_val at cycle base_c and advances once per TD cycles.
    logic [63:0] base_val;
    longint      base_c;
    logic [63:0] cmp_m;
    logic        msip_m;
    rsp_t        sbq[$];

    bit     chk_on   = 1'b0;
    bit     ack_en   = 1'b1;
    bit     rsp_block = 1'b0;
    longint hold_until = 0;

    function automatic logic [63:0] mt_at(input longint c);
        return base_val + 64'((c - base_c) / longint'(TD));
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] w,
                                          input logic [7:0] m);
        logic [63:0] lane;
        for (int i = 0; i < 8; i++) lane[i*8 +: 8] = {8{m[i]}};
        return (old_v & ~lane) | (w & lane);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request; the expected response is pushed when the request is accepted.
    task automatic issue(input logic wen, input logic [15:0] addr, input logic [63:0] wd,
                         input logic [7:0] wm);
        rsp_t   e;
        longint k;
        int     guard;
        guard = 0;
        while (!bus.req_ready) begin
            if (guard++ > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL req_ready_timeout: actual=0 expected=1 (cycle %0d)", cyc);
                return;
            end
            step();
        end
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        k = cyc;
        e = '0;
        e.err = !(addr == 16'h0000 || addr == 16'h4000 || addr == 16'hBFF8);
        if (!wen) begin
            case (addr)
                16'h0000: e.rdata = {63'b0, msip_m};
                16'h4000: e.rdata = cmp_m;
                16'hBFF8: e.rdata = mt_at(k);
                default:  e.rdata = 64'd0;
            endcase
        end
        sbq.push_back(e);
        step();
        bus.req_valid = 1'b0;
        if (wen) begin
            case (addr)
`ifdef YSYX_220066_CLINT_SWI_EN
                16'h0000: if (wm[0]) msip_m = wd[0];
`endif
                16'h4000: cmp_m = merge(cmp_m, wd, wm);
                16'hBFF8: begin
                    base_val = merge(mt_at(k), wd, wm);
                    base_c   = k + 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        step();
        rst = 1'b0;
        sbq.delete();
        base_val = '0;
        base_c   = cyc;
        cmp_m    = '1;
        msip_m   = 1'b0;
    endtask

    task automatic wait_intr(input int bound);
        int n;
        n = 0;
        while (!intr_req && n < bound) begin
            step();
            n++;
        end
        check("intr_req_seen", intr_req, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((!bus.req_ready || sbq.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    // Response monitor: drives resp_ready, pops the scoreboard on each handshake.
    initial begin : monitor
        rsp_t        e;
        logic        pv, pr, prst, perr;
        logic [63:0] pd;
        pv = 1'b0; pr = 1'b0; prst = 1'b1; perr = 1'b0; pd = '0;
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_block || cyc < hold_until) bus.resp_ready = 1'b0;
            else bus.resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (chk_on) begin
                if (bus.resp_valid) check("req_ready_in_resp", bus.req_ready, 1'b0);
                if (pv && !pr && !prst) begin
                    check("resp_valid_held", bus.resp_valid, 1'b1);
                    check("resp_rdata_stable", bus.resp_rdata, pd);
                    check("resp_err_stable", bus.resp_err, perr);
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: actual=%h expected=none (cycle %0d)",
                                 bus.resp_rdata, cyc);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_err", bus.resp_err, e.err);
                    end
                end
            end
            pv = bus.resp_valid; pr = bus.resp_ready; prst = rst;
            pd = bus.resp_rdata; perr = bus.resp_err;
        end
    end

    // Interrupt side: random acknowledges, and per-cycle check of pending bits and request.
    initial begin : intr_side
        logic        exp_req, mt_pend;
        logic [63:0] exp_no;
        int          quiet;
        exp_req = 1'b0; exp_no = '0; quiet = 0;
        intr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            intr_ack = ack_en && intr_req && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (chk_on) begin
                mt_pend = (mt_at(cyc) >= cmp_m);
                check("mtip", mtip, mt_pend);
                check("msip_o", msip_o, msip_m);
                check("intr_req", intr_req, exp_req);
                check("intr_no", intr_no, exp_no);
                if (rst) begin
                    exp_req = 1'b0; exp_no = '0; quiet = 0;
                end else if (exp_req) begin
                    if (intr_ack) begin
                        exp_req = 1'b0;
                        quiet   = 1;
                    end
                end else if (quiet > 0) begin
                    quiet--;
                end else if (intr_en && (msip_m || mt_pend)) begin
                    exp_req = 1'b1;
                    exp_no  = msip_m ? C_SOFT : C_TIMER;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] r;
        logic [15:0] a;
        logic [63:0] wd;
        logic [7:0]  wm;
        rst = 1'b1;
        intr_en = 1'b0;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;  bus.req_wmask = '0;
        base_val = '0; base_c = 0; cmp_m = '1; msip_m = 1'b0;
        repeat (2) step();
        do_reset();
        chk_on = 1'b1;

        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_err", bus.resp_err, 1'b0);
        check("rst_intr_no", intr_no, 64'd0);

        // Free-running mtime after 40 idle cycles.
        repeat (40) step();
        issue(1'b0, 16'hBFF8, '0, '0);

        // Timer interrupt 20 ticks ahead, acknowledged randomly.
        intr_en = 1'b1;
        issue(1'b1, 16'h4000, mt_at(cyc) + 64'd20, 8'hFF);
        wait_intr(200);
        repeat (30) step();

        // Software interrupt while the timer is also pending.
        intr_en = 1'b0;
        issue(1'b1, 16'h4000, 64'd0, 8'hFF);
        repeat (10) step();
        issue(1'b1, 16'h0000, 64'h1, 8'h01);
        intr_en = 1'b1;
        repeat (12) step();
        issue(1'b0, 16'h0000, '0, '0);
        issue(1'b1, 16'h0000, 64'h0, 8'hFF);
        intr_en = 1'b0;
        issue(1'b1, 16'h4000, '1, 8'hFF);

        // Wrap-around, then mtime writes at varying prescaler phases.
        issue(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        repeat (10) step();
        issue(1'b0, 16'hBFF8, '0, '0);
        for (int i = 0; i < 8; i++) begin
            repeat (i) step();
            issue(1'b1, 16'hBFF8, {$urandom, $urandom}, 8'hFF);
            issue(1'b0, 16'hBFF8, '0, '0);
        end
        issue(1'b1, 16'hBFF8, 64'h0123_4567_89AB_CDEF, 8'h0F);
        issue(1'b0, 16'hBFF8, '0, '0);

        // Unmapped/misaligned accesses leave state alone.
        issue(1'b0, 16'h1234, '0, '0);
        issue(1'b0, 16'h4004, '0, '0);
        issue(1'b1, 16'h4001, 64'd5, 8'hFF);
        issue(1'b1, 16'h0008, 64'd7, 8'hFF);
        issue(1'b0, 16'h4000, '0, '0);

        // Response held under back-pressure.
        drain();
        hold_until = cyc + 6;
        issue(1'b0, 16'h4000, '0, '0);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            case (r[2:0])
                3'd0:    a = 16'h0000;
                3'd1:    a = 16'h4000;
                3'd2:    a = 16'hBFF8;
                3'd3:    a = 16'h4000;
                3'd4:    a = {r[31:19], 3'b000};
                3'd5:    a = r[31:16];
                default: a = 16'hBFF8;
            endcase
            wd = {$urandom, $urandom};
            if (a == 16'h4000 && r[8]) wd = mt_at(cyc) + 64'($urandom_range(0, 40));
            if (a == 16'hBFF8 && r[9]) wd = {32'd0, $urandom_range(0, 200)};
            wm = r[10] ? 8'hFF : r[18:11];
            intr_en = (r[25:24] != 2'b00);
            issue(r[3], a, wd, wm);
            repeat (r[27:26] % 3) step();
        end
        drain();

        // Reset while a response is pending.
        intr_en = 1'b0;
        rsp_block = 1'b1;
        issue(1'b0, 16'h4000, '0, '0);
        check("resp_pending", bus.resp_valid, 1'b1);
        do_reset();
        rsp_block = 1'b0;
        check("rst_resp_drop", bus.resp_valid, 1'b0);
        check("rst_ready_back", bus.req_ready, 1'b1);
        issue(1'b0, 16'hBFF8, '0, '0);
        issue(1'b0, 16'h4000, '0, '0);

        // Reset while an interrupt request is held.
        ack_en = 1'b0;
        issue(1'b1, 16'h4000, 64'd0, 8'hFF);
        intr_en = 1'b1;
        wait_intr(20);
        repeat (3) step();
        do_reset();
        intr_en = 1'b0;
        ack_en = 1'b1;
        check("rst_intr_drop", intr_req, 1'b0);
        check("rst_intr_no_clear", intr_no, 64'd0);
        issue(1'b0, 16'hBFF8, '0, '0);
        issue(1'b0, 16'h4000, '0, '0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
